// File: rtl/game_pkg.sv
// game_pkg: shared game state codes, display constants and score-timer FSM states
package game_pkg;
  localparam logic [2:0] STATE_IDLE  = 3'b000;
  localparam logic [2:0] STATE_READY = 3'b001;
  localparam logic [2:0] STATE_PLAY  = 3'b010;
  localparam logic [2:0] STATE_OVER  = 3'b011;
  localparam logic [3:0] BCD_BLANK   = 4'd10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: 3-digit BCD plus small binary addend, saturating at 999
module bcd_add3 (
  input  logic [3:0] i_d100,
  input  logic [3:0] i_d10,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_add,
  output logic [3:0] o_d100,
  output logic [3:0] o_d10,
  output logic [3:0] o_d1
);
  logic [4:0] w_s1, w_s10, w_s100;
  logic       w_c1, w_c10, w_c100;
  assign w_s1   = {1'b0, i_d1} + {1'b0, i_add};
  assign w_c1   = w_s1 > 5'd9;
  assign w_s10  = {1'b0, i_d10} + {4'd0, w_c1};
  assign w_c10  = w_s10 > 5'd9;
  assign w_s100 = {1'b0, i_d100} + {4'd0, w_c10};
  assign w_c100 = w_s100 > 5'd9;
  // a carry out of the hundreds digit means the true sum passed 999
  assign o_d1   = w_c100 ? 4'd9 : w_c1  ? 4'(w_s1 - 5'd10)  : w_s1[3:0];
  assign o_d10  = w_c100 ? 4'd9 : w_c10 ? 4'(w_s10 - 5'd10) : w_s10[3:0];
  assign o_d100 = w_c100 ? 4'd9 : w_s100[3:0];
endmodule

// File: rtl/game_score_timer.sv
// game_score_timer: BCD score keeper and round countdown with one-cycle time_up pulse
module game_score_timer
  import game_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 1000,
  parameter logic [2:0] COUNT_INIT    = 3'd7,
  parameter logic [3:0] BONUS_PTS     = 4'd5
) (
  input  logic       Game_clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       hit,
  input  logic       bonus,
  output logic [3:0] score100,
  output logic [3:0] score10,
  output logic [3:0] score1,
  output logic [2:0] countDown,
  output logic       time_up
);
  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  fsm_t          r_fsm, w_fsm_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic [2:0]    r_cd, w_cd_n;
  logic [3:0]    r_s100, r_s10, r_s1, w_s100_n, w_s10_n, w_s1_n;
  logic [3:0]    w_a100, w_a10, w_a1, w_add;
  logic          r_prev_play, r_time_up, w_time_up_n;
  logic          w_play, w_entry, w_wrap;
  assign w_play  = state == STATE_PLAY;
  assign w_entry = w_play & ~r_prev_play;
  assign w_wrap  = r_tick == TICK_MAX;
  assign w_add   = (hit ? 4'd1 : 4'd0) + (bonus ? BONUS_PTS : 4'd0);
  bcd_add3 u_add (
    .i_d100(r_s100),
    .i_d10 (r_s10),
    .i_d1  (r_s1),
    .i_add (w_add),
    .o_d100(w_a100),
    .o_d10 (w_a10),
    .o_d1  (w_a1)
  );
  always_comb begin
    w_fsm_n     = r_fsm;
    w_tick_n    = r_tick;
    w_cd_n      = r_cd;
    w_s100_n    = r_s100;
    w_s10_n     = r_s10;
    w_s1_n      = r_s1;
    w_time_up_n = 1'b0;
    case (r_fsm)
      IDLE: if (w_entry) begin
        w_fsm_n  = RUN;
        w_tick_n = '0;
        w_cd_n   = COUNT_INIT;
        w_s100_n = 4'd0;
        w_s10_n  = 4'd0;
        w_s1_n   = 4'd0;
      end
      RUN: if (!w_play) begin
        w_fsm_n  = IDLE;
        w_tick_n = '0;
      end else begin
        w_s100_n = w_a100;
        w_s10_n  = w_a10;
        w_s1_n   = w_a1;
        w_tick_n = w_wrap ? '0 : r_tick + TW'(1);
        w_cd_n   = w_wrap ? r_cd - 3'd1 : r_cd;
        w_time_up_n = w_wrap && r_cd == 3'd1;
        w_fsm_n  = w_time_up_n ? DONE : RUN;
      end
      default: w_fsm_n = w_play ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge Game_clk or negedge reset) begin
    if (!reset) begin
      r_fsm       <= IDLE;
      r_tick      <= '0;
      r_cd        <= 3'd0;
      r_s100      <= 4'd0;
      r_s10       <= 4'd0;
      r_s1        <= 4'd0;
      r_prev_play <= 1'b0;
      r_time_up   <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_n;
      r_tick      <= w_tick_n;
      r_cd        <= w_cd_n;
      r_s100      <= w_s100_n;
      r_s10       <= w_s10_n;
      r_s1        <= w_s1_n;
      r_prev_play <= w_play;
      r_time_up   <= w_time_up_n;
    end
  end
  assign score100  = r_s100;
  assign score10   = r_s10;
  assign score1    = r_s1;
  assign countDown = r_cd;
  assign time_up   = r_time_up;
endmodule

// File: tb/tb_game_score_timer.sv
// tb_game_score_timer: vector table, corner sequences and random run against a round/score model
module tb_game_score_timer;
  logic       Game_clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'd0;
  logic       hit = 1'b0;
  logic       bonus = 1'b0;
  logic [3:0] a_s100, a_s10, a_s1, b_s100, b_s10, b_s1;
  logic [2:0] a_cd, b_cd;
  logic       a_tu, b_tu;
  int n_chk = 0;
  int n_err = 0;
  always #5 Game_clk = ~Game_clk;
  game_score_timer #(.TICKS_PER_SEC(4), .COUNT_INIT(3'd3), .BONUS_PTS(4'd5)) dut_a (
    .Game_clk(Game_clk), .reset(reset), .state(state), .hit(hit), .bonus(bonus),
    .score100(a_s100), .score10(a_s10), .score1(a_s1), .countDown(a_cd), .time_up(a_tu));
  game_score_timer #(.TICKS_PER_SEC(1000), .COUNT_INIT(3'd7), .BONUS_PTS(4'd5)) dut_b (
    .Game_clk(Game_clk), .reset(reset), .state(state), .hit(hit), .bonus(bonus),
    .score100(b_s100), .score10(b_s10), .score1(b_s1), .countDown(b_cd), .time_up(b_tu));
  typedef struct {
    int score;
    int elapsed;
    int cd;
    bit active;
    bit finished;
    bit prev;
    bit tu;
  } mdl_t;
  typedef struct {
    logic [2:0] st;
    logic       h;
    logic       b;
    int         score;
    int         cd;
    int         tu;
  } vec_t;
  mdl_t ma, mb;
  vec_t tbl[$];
  function automatic vec_t v(logic [2:0] st, logic h, logic b, int score, int cd, int tu);
    vec_t r;
    r.st = st; r.h = h; r.b = b; r.score = score; r.cd = cd; r.tu = tu;
    return r;
  endfunction
  // a round lasts ci*t scoring cycles; remaining seconds follow from elapsed cycles
  function automatic mdl_t step(mdl_t m, int t, int ci, logic [2:0] st, logic h, logic b);
    bit play;
    play = st == 3'b010;
    m.tu = 0;
    if (m.active) begin
      if (!play) m.active = 0;
      else begin
        m.score = m.score + int'(h) + 5 * int'(b);
        if (m.score > 999) m.score = 999;
        m.elapsed++;
        m.cd = ci - m.elapsed / t;
        if (m.cd == 0) begin
          m.tu = 1; m.active = 0; m.finished = 1;
        end
      end
    end else if (m.finished) begin
      if (!play) m.finished = 0;
    end else if (play && !m.prev) begin
      m.active = 1; m.score = 0; m.elapsed = 0; m.cd = ci;
    end
    m.prev = play;
    return m;
  endfunction
  task automatic check(string nm, logic [31:0] act, int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(string tag, logic [3:0] s100, logic [3:0] s10, logic [3:0] s1,
                         logic [2:0] cd, logic tu, int score, int ecd, int etu);
    check({tag, ".score100"}, 32'(s100), score / 100);
    check({tag, ".score10"}, 32'(s10), (score / 10) % 10);
    check({tag, ".score1"}, 32'(s1), score % 10);
    check({tag, ".countDown"}, 32'(cd), ecd);
    check({tag, ".time_up"}, 32'(tu), etu);
  endtask
  task automatic cyc(logic [2:0] st, logic h, logic b);
    state = st; hit = h; bonus = b;
    @(posedge Game_clk);
    ma = step(ma, 4, 3, st, h, b);
    mb = step(mb, 1000, 7, st, h, b);
    #1;
    chk_all("A", a_s100, a_s10, a_s1, a_cd, a_tu, ma.score, ma.cd, int'(ma.tu));
    chk_all("B", b_s100, b_s10, b_s1, b_cd, b_tu, mb.score, mb.cd, int'(mb.tu));
  endtask
  task automatic cycn(int n, logic [2:0] st, logic h, logic b);
    for (int i = 0; i < n; i++) cyc(st, h, b);
  endtask
  initial begin
    logic [2:0] rst_st;
    ma = '{default: 0};
    mb = '{default: 0};
    tbl.push_back(v(3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(v(3'd2, 1, 0, 0, 3, 0));
    tbl.push_back(v(3'd2, 1, 0, 1, 3, 0));
    tbl.push_back(v(3'd2, 0, 1, 6, 3, 0));
    tbl.push_back(v(3'd2, 0, 0, 6, 3, 0));
    tbl.push_back(v(3'd2, 1, 1, 12, 2, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(3'd2, 0, 0, 12, 2, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(3'd2, 0, 0, 12, 1, 0));
    tbl.push_back(v(3'd2, 1, 0, 13, 0, 1));
    tbl.push_back(v(3'd2, 1, 0, 13, 0, 0));
    tbl.push_back(v(3'd0, 0, 0, 13, 0, 0));
    tbl.push_back(v(3'd2, 0, 1, 0, 3, 0));
    tbl.push_back(v(3'd2, 1, 0, 1, 3, 0));
    tbl.push_back(v(3'd2, 0, 0, 1, 3, 0));
    tbl.push_back(v(3'd2, 0, 0, 1, 3, 0));
    tbl.push_back(v(3'd2, 0, 0, 1, 2, 0));
    tbl.push_back(v(3'd3, 1, 0, 1, 2, 0));
    tbl.push_back(v(3'd7, 0, 1, 1, 2, 0));
    tbl.push_back(v(3'd2, 0, 0, 0, 3, 0));
    #2 reset = 1'b0;
    repeat (2) @(posedge Game_clk);
    #1;
    chk_all("rst.A", a_s100, a_s10, a_s1, a_cd, a_tu, 0, 0, 0);
    chk_all("rst.B", b_s100, b_s10, b_s1, b_cd, b_tu, 0, 0, 0);
    @(negedge Game_clk);
    reset = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].h, tbl[i].b);
      chk_all($sformatf("vec%0d", i), a_s100, a_s10, a_s1, a_cd, a_tu,
              tbl[i].score, tbl[i].cd, tbl[i].tu);
    end
    cyc(3'd2, 0, 1);
    cycn(3, 3'd2, 1, 0);
    chk_all("B.8", b_s100, b_s10, b_s1, b_cd, b_tu, 8, 7, 0);
    cyc(3'd2, 1, 1);
    chk_all("B.hit_bonus", b_s100, b_s10, b_s1, b_cd, b_tu, 14, 7, 0);
    cycn(17, 3'd2, 0, 1);
    chk_all("B.99", b_s100, b_s10, b_s1, b_cd, b_tu, 99, 7, 0);
    cyc(3'd2, 0, 1);
    chk_all("B.double_carry", b_s100, b_s10, b_s1, b_cd, b_tu, 104, 7, 0);
    cycn(178, 3'd2, 0, 1);
    cycn(3, 3'd2, 1, 0);
    chk_all("B.997", b_s100, b_s10, b_s1, b_cd, b_tu, 997, 7, 0);
    cyc(3'd2, 0, 1);
    chk_all("B.sat", b_s100, b_s10, b_s1, b_cd, b_tu, 999, 7, 0);
    cyc(3'd2, 1, 0);
    chk_all("B.sat_hold", b_s100, b_s10, b_s1, b_cd, b_tu, 999, 7, 0);
    cyc(3'd0, 0, 0);
    cyc(3'd2, 0, 0);
    cyc(3'd2, 1, 0);
    cyc(3'd2, 0, 0);
    chk_all("A.pre_rst", a_s100, a_s10, a_s1, a_cd, a_tu, 1, 3, 0);
    #2 reset = 1'b0;
    #1;
    chk_all("midrst.A", a_s100, a_s10, a_s1, a_cd, a_tu, 0, 0, 0);
    chk_all("midrst.B", b_s100, b_s10, b_s1, b_cd, b_tu, 0, 0, 0);
    ma = '{default: 0};
    mb = '{default: 0};
    #2 reset = 1'b1;
    cycn(3, 3'd0, 1, 1);
    chk_all("post_rst.A", a_s100, a_s10, a_s1, a_cd, a_tu, 0, 0, 0);
    cyc(3'd2, 1, 0);
    chk_all("reentry.A", a_s100, a_s10, a_s1, a_cd, a_tu, 0, 3, 0);
    chk_all("reentry.B", b_s100, b_s10, b_s1, b_cd, b_tu, 0, 7, 0);
    rst_st = 3'b010;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        rst_st = $urandom_range(0, 1) ? 3'b010 : 3'($urandom_range(0, 7));
      cyc(rst_st, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
